// File: rtl/msfsm_cfg_pkg.sv
// ---------------------------------------------------------------------------
// msfsm_cfg_pkg
// Shared types and constants for the MSFSM bank configuration loader.
//   state_t   : loader sequencer states
//   ERR_*     : err_code values reported on o_err_code
//   wpf()     : number of host words that make up one FSM config chain
// ---------------------------------------------------------------------------
package msfsm_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        WAIT,
        SHIFT,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;   // no error
    localparam logic [1:0] ERR_IDX  = 2'd1;   // target index beyond the bank
    localparam logic [1:0] ERR_LEN  = 2'd2;   // word count / last marker disagree
    localparam logic [1:0] ERR_DUP  = 2'd3;   // target FSM already fully loaded

    // Words per FSM config chain.
    function automatic int wpf(input int cfg_bits, input int word_w);
        return cfg_bits / word_w;
    endfunction

endpackage

// File: rtl/msfsm_cfg_shifter.sv
// ---------------------------------------------------------------------------
// msfsm_cfg_shifter
// Parallel-load, MSB-first serialiser for one host word.
//   clk, rst_n   : clock / async active-low reset
//   i_clear      : drop any word in flight (abort)
//   i_load       : capture i_word; bit_out shows word MSB on the next cycle
//   i_word       : word to serialise
//   o_bit_out    : current serial bit (registered)
//   o_active     : a word is being shifted out
//   o_last_bit   : current cycle carries the final bit of the word
// ---------------------------------------------------------------------------
module msfsm_cfg_shifter #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_bit_out,
    output logic              o_active,
    output logic              o_last_bit
);
    localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] r_sr;
    logic [CW-1:0]     r_cnt;
    logic              r_active;
    logic              w_last;

    assign w_last = r_active && (r_cnt == CW'(WORD_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_clear) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_sr     <= i_word;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            // Zero-fill so the serial line idles low once the word is out.
            r_sr  <= r_sr << 1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_bit_out  = r_sr[WORD_W-1];
    assign o_active   = r_active;
    assign o_last_bit = w_last;

endmodule

// File: rtl/msfsm_cfg_loader.sv
// ---------------------------------------------------------------------------
// msfsm_cfg_loader
// Serially loads every FSM of the MSFSM bank from host words and holds the
// bank in synchronous reset until all chains are complete.
//   clk, rst_n      : clock / async active-low reset
//   i_load_start    : pulse, (re)start a full bank load from any state
//   i_cfg_valid     : host word valid
//   o_cfg_ready     : loader can take a word (valid & ready = transfer)
//   i_cfg_data      : host word, shifted out MSB first
//   i_cfg_fsm       : target FSM index
//   i_cfg_last      : final word for the target FSM
//   o_fsm_en        : one-hot per-FSM shift strobe
//   o_fsm_d         : serial config bit
//   o_fsm_sreset    : synchronous reset to the bank
//   o_busy / o_done / o_err / o_err_code : loader status
// ---------------------------------------------------------------------------
module msfsm_cfg_loader
    import msfsm_cfg_pkg::*;
#(
    parameter int N_FSM    = 7,
    parameter int CFG_BITS = 32,
    parameter int WORD_W   = 8,
    parameter int RST_CYC  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load_start,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic [WORD_W-1:0]        i_cfg_data,
    input  logic [$clog2(N_FSM)-1:0] i_cfg_fsm,
    input  logic                     i_cfg_last,
    output logic [N_FSM-1:0]         o_fsm_en,
    output logic                     o_fsm_d,
    output logic                     o_fsm_sreset,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [1:0]               o_err_code
);
    localparam int FW    = $clog2(N_FSM);
    localparam int FSZ   = 1 << FW;
    localparam int WPF_C = wpf(CFG_BITS, WORD_W);
    localparam int WCW   = $clog2(WPF_C + 1);
    localparam int RCW   = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t           r_state;
    logic [N_FSM-1:0] r_loaded;
    logic [N_FSM-1:0] r_en;
    logic [WCW-1:0]   r_wc;
    logic [FW-1:0]    r_tgt;
    logic             r_last;
    logic [RCW-1:0]   r_rst_cnt;
    logic             r_ready;
    logic             r_sreset;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic [N_FSM-1:0] w_in_oh;
    logic [N_FSM-1:0] w_tgt_oh;
    logic [FSZ-1:0]   w_loaded_pad;
    logic             w_idx_bad;
    logic             w_dup;
    logic             w_switch;
    logic [WCW-1:0]   w_wc_inc;
    logic             w_full;
    logic             w_accept;
    logic             w_bit_out;
    logic             w_active;
    logic             w_last_bit;

    genvar gi;
    generate
        for (gi = 0; gi < N_FSM; gi++) begin : g_dec
            assign w_in_oh[gi]  = (i_cfg_fsm == FW'(gi));
            assign w_tgt_oh[gi] = (r_tgt == FW'(gi));
        end
    endgenerate

    // Padded so an out-of-range index reads as "not loaded" instead of
    // indexing past the mask.
    assign w_loaded_pad = FSZ'(r_loaded);
    assign w_idx_bad    = ({1'b0, i_cfg_fsm} >= (FW + 1)'(N_FSM));
    assign w_dup        = w_loaded_pad[i_cfg_fsm];
    // A partial chain is open whenever the word counter is non-zero.
    assign w_switch     = (r_wc != '0) && (i_cfg_fsm != r_tgt);
    assign w_wc_inc     = r_wc + 1'b1;
    assign w_full       = (w_wc_inc == WCW'(WPF_C));
    assign w_accept     = (r_state == WAIT) && r_ready && i_cfg_valid && !i_load_start
                          && !w_idx_bad && !w_dup && !w_switch;

    msfsm_cfg_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (i_load_start),
        .i_load     (w_accept),
        .i_word     (i_cfg_data),
        .o_bit_out  (w_bit_out),
        .o_active   (w_active),
        .o_last_bit (w_last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_loaded   <= '0;
            r_en       <= '0;
            r_wc       <= '0;
            r_tgt      <= '0;
            r_last     <= 1'b0;
            r_rst_cnt  <= '0;
            r_ready    <= 1'b0;
            r_sreset   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (i_load_start) begin
            // Restart from anywhere, including mid-shift.
            r_state    <= RST;
            r_loaded   <= '0;
            r_en       <= '0;
            r_wc       <= '0;
            r_rst_cnt  <= '0;
            r_ready    <= 1'b0;
            r_sreset   <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                end
                RST: begin
                    if (r_rst_cnt == RCW'(RST_CYC - 1)) begin
                        r_state <= WAIT;
                        r_ready <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (i_cfg_valid) begin
                        r_ready <= 1'b0;
                        if (w_idx_bad || w_dup || w_switch) begin
                            r_state    <= ERR;
                            r_err      <= 1'b1;
                            r_busy     <= 1'b0;
                            r_err_code <= w_idx_bad ? ERR_IDX : (w_dup ? ERR_DUP : ERR_LEN);
                        end else begin
                            r_state <= SHIFT;
                            r_tgt   <= i_cfg_fsm;
                            r_last  <= i_cfg_last;
                            r_en    <= w_in_oh;
                        end
                    end
                end
                SHIFT: begin
                    if (w_last_bit) begin
                        r_en <= '0;
                        if (r_last != w_full) begin
                            r_state    <= ERR;
                            r_err      <= 1'b1;
                            r_busy     <= 1'b0;
                            r_err_code <= ERR_LEN;
                        end else if (r_last && ((r_loaded | w_tgt_oh) == '1)) begin
                            r_loaded <= r_loaded | w_tgt_oh;
                            r_wc     <= '0;
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_sreset <= 1'b0;
                        end else begin
                            if (r_last) begin
                                r_loaded <= r_loaded | w_tgt_oh;
                                r_wc     <= '0;
                            end else begin
                                r_wc <= w_wc_inc;
                            end
                            r_state <= WAIT;
                            r_ready <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cfg_ready  = r_ready;
    assign o_fsm_en     = r_en;
    assign o_fsm_d      = w_bit_out;
    assign o_fsm_sreset = r_sreset;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;

    // Shifter activity always tracks the en strobe; kept only as a
    // cross-check signal for debug probes.
    logic w_unused;
    assign w_unused = w_active;

endmodule

// File: tb/tb_msfsm_cfg_loader.sv
module tb_msfsm_cfg_loader;
    localparam int N_FSM    = 7;
    localparam int CFG_BITS = 32;
    localparam int WORD_W   = 8;
    localparam int RST_CYC  = 4;
    localparam int WPF      = CFG_BITS / WORD_W;
    localparam int FW       = $clog2(N_FSM);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              load_start = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_last = 1'b0;
    logic [WORD_W-1:0] cfg_data = '0;
    logic [FW-1:0]     cfg_fsm = '0;
    logic              cfg_ready;
    logic [N_FSM-1:0]  fsm_en;
    logic              fsm_d;
    logic              fsm_sreset;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    msfsm_cfg_loader #(
        .N_FSM(N_FSM), .CFG_BITS(CFG_BITS), .WORD_W(WORD_W), .RST_CYC(RST_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_load_start(load_start),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_data(cfg_data),
        .i_cfg_fsm(cfg_fsm), .i_cfg_last(cfg_last), .o_fsm_en(fsm_en),
        .o_fsm_d(fsm_d), .o_fsm_sreset(fsm_sreset), .o_busy(busy),
        .o_done(done), .o_err(err), .o_err_code(err_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int fsm;
        bit d;
    } bit_t;
    bit_t sb_q[$];

    // Reference model: which FSMs hold a complete chain, which one is
    // partially loaded, and how many of its words have arrived.
    bit [N_FSM-1:0] m_loaded;
    int  m_open;
    int  m_cnt;
    int  m_code;
    bit  m_late;
    time t_xfer;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobed bit must be the next one the model predicted.
    always @(negedge clk) begin
        bit_t e;
        if (rst_n && fsm_en != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_en", fsm_en, 0);
            end else begin
                e = sb_q.pop_front();
                chk("fsm_en", fsm_en, longint'(1) << e.fsm);
                chk("fsm_d", fsm_d, e.d);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, cfg_ready, 0);
        chk({tag, "_en"}, fsm_en, 0);
        chk({tag, "_d"}, fsm_d, 0);
        chk({tag, "_sreset"}, fsm_sreset, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_code"}, err_code, 0);
    endtask

    // Called on a negedge; returns on the negedge where ready is first high.
    task automatic pulse_start();
        int  k;
        time t0;
        load_start = 1'b1;
        @(posedge clk);
        t0 = $time;
        @(negedge clk);
        load_start = 1'b0;
        sb_q.delete();
        m_loaded = '0; m_open = -1; m_cnt = 0; m_code = 0; m_late = 0;
        chk("start_en", fsm_en, 0);
        chk("start_busy", busy, 1);
        chk("start_sreset", fsm_sreset, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        k = 0;
        while (!cfg_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        // RST_CYC cycles in reset, ready visible the following half period.
        chk("rst_len", longint'($time - t0), 10 * RST_CYC + 5);
    endtask

    task automatic xfer(input int fsm, input logic [WORD_W-1:0] data, input bit last, input int hold);
        int k;
        int h;
        cfg_fsm   = FW'(fsm);
        cfg_data  = data;
        cfg_last  = last;
        cfg_valid = 1'b1;
        k = 0;
        while (!cfg_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cfg_ready) begin
            chk("ready_timeout", cfg_ready, 1);
            cfg_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_xfer = $time;
        h = hold;
        if (fsm >= N_FSM) begin
            m_code = 1;
        end else if (m_loaded[fsm]) begin
            m_code = 3;
        end else if (m_open >= 0 && m_open != fsm) begin
            m_code = 2;
        end else begin
            for (int b = WORD_W - 1; b >= 0; b--) sb_q.push_back('{fsm, data[b]});
            m_cnt++;
            m_open = fsm;
            if (last != (m_cnt == WPF)) begin
                m_code = 2;
                m_late = 1;
            end else if (last) begin
                m_loaded[fsm] = 1'b1;
                m_cnt = 0;
                m_open = -1;
            end
        end
        if (m_code != 0 && !m_late) h = 0;
        // valid stays high while ready is low: must not be taken twice.
        repeat (h + 1) @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic load_one(input int fsm, input bit rnd);
        for (int w = 0; w < WPF; w++) begin
            if (m_code != 0) return;
            xfer(fsm, rnd ? WORD_W'($urandom_range(255, 0)) : 8'hA5, w == WPF - 1,
                 rnd ? int'($urandom_range(7, 0)) : 0);
        end
    endtask

    task automatic finish_check(input string tag);
        int k;
        bit exp_done;
        exp_done = (m_code == 0) && (m_loaded == '1);
        k = 0;
        while (!(done || err) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, longint'($time - t_xfer),
            (m_code != 0 && !m_late) ? 5 : 10 * WORD_W + 5);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_err"}, err, m_code != 0);
        chk({tag, "_code"}, err_code, m_code);
        chk({tag, "_sreset"}, fsm_sreset, !exp_done);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, cfg_ready, 0);
        chk({tag, "_en"}, fsm_en, 0);
        chk({tag, "_leftover"}, sb_q.size(), 0);
    endtask

    task automatic load_order(input int o0, input int o1, input int o2, input int o3,
                              input int o4, input int o5, input int o6, input bit rnd);
        int ord[7];
        ord = '{o0, o1, o2, o3, o4, o5, o6};
        for (int i = 0; i < N_FSM; i++) load_one(ord[i], rnd);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[7];
        int j;
        int t;
        m_open = -1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("idle");

        // In-order load, constant 0xA5 words.
        pulse_start();
        load_order(0, 1, 2, 3, 4, 5, 6, 1'b0);
        finish_check("inorder");

        // Out-of-order load with random data and valid hold-over.
        pulse_start();
        load_order(6, 2, 0, 5, 1, 4, 3, 1'b1);
        finish_check("ooo");

        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < N_FSM; i++) ord[i] = i;
            for (int i = N_FSM - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            pulse_start();
            load_order(ord[0], ord[1], ord[2], ord[3], ord[4], ord[5], ord[6], 1'b1);
            finish_check("rand");
        end

        // Index beyond the bank.
        pulse_start();
        load_one(0, 1'b1);
        xfer(7, 8'h3C, 1'b0, 0);
        finish_check("err_idx");

        // Reload of a completed FSM.
        pulse_start();
        load_one(2, 1'b1);
        xfer(2, 8'h11, 1'b0, 0);
        finish_check("err_dup");

        // Last marker on the third word.
        pulse_start();
        xfer(1, 8'h01, 1'b0, 0);
        xfer(1, 8'h02, 1'b0, 3);
        xfer(1, 8'h03, 1'b1, 2);
        finish_check("err_short");

        // Missing last marker on the final word.
        pulse_start();
        for (int w = 0; w < WPF; w++) xfer(4, WORD_W'($urandom_range(255, 0)), 1'b0, 1);
        finish_check("err_long");

        // Switching target with a chain still open.
        pulse_start();
        xfer(5, 8'hF0, 1'b0, 0);
        xfer(3, 8'h0F, 1'b0, 0);
        finish_check("err_switch");

        // Restart while FSM3 is on bit 5, then a clean full reload.
        pulse_start();
        load_order(0, 1, 2, 0, 0, 0, 0, 1'b1);
        pulse_start();
        load_one(0, 1'b1); load_one(1, 1'b1); load_one(2, 1'b1);
        xfer(3, 8'h5A, 1'b0, 0);
        repeat (5) @(negedge clk);
        pulse_start();
        load_order(3, 6, 5, 4, 2, 1, 0, 1'b1);
        finish_check("abort");

        // Async reset mid-shift.
        pulse_start();
        xfer(0, 8'hC3, 1'b0, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_rst");
        pulse_start();
        load_order(1, 3, 5, 0, 2, 4, 6, 1'b1);
        finish_check("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
